// File: rtl/clip_sequencer.sv
// clip_sequencer: record/playback sequencer for two clip memories.
// Tracks per-clip sample counts so playback ends where recording ended.
module clip_sequencer #(
  parameter int ADDR_W   = 14,
  parameter int CLIP_LEN = 16000
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              rec_req,
  input  logic              play_req,
  input  logic              stop,
  input  logic              clip_sel,
  input  logic              sample_tick,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [1:0]        mem_en,
  output logic [1:0]        mem_we,
  output logic              busy,
  output logic              done,
  output logic              reject,
  output logic [1:0]        clip_valid
);

  localparam int LEN_W = ADDR_W + 1;
  localparam logic [LEN_W-1:0] REC_LIM = LEN_W'(CLIP_LEN);
  localparam logic [LEN_W-1:0] ONE     = LEN_W'(1);

  typedef enum logic [1:0] {IDLE, REC, PLAY, DONE} state_t;

  state_t            state;
  state_t            state_nx;
  logic              cur_clip;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  len [2];
  logic              reject_q;

  logic [LEN_W-1:0]  limit;
  logic [LEN_W-1:0]  addr_ext;
  logic [LEN_W-1:0]  count;
  logic              fin;
  logic              sel_empty;

  // Termination test and access count for the current operation
  always_comb begin
    limit     = (state == REC) ? REC_LIM : len[cur_clip];
    addr_ext  = {1'b0, addr};
    count     = addr_ext + LEN_W'(sample_tick);
    fin       = (sample_tick && (addr_ext == limit - ONE)) || stop;
    sel_empty = (len[clip_sel] == '0);
  end

  // State register
  always_ff @(posedge clock) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  // Next-state logic; record wins over play
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE: begin
        if (rec_req)                     state_nx = REC;
        else if (play_req && !sel_empty) state_nx = PLAY;
      end
      REC, PLAY: if (fin) state_nx = DONE;
      DONE: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Address counter, clip lengths, target clip and reject pulse
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      addr     <= '0;
      len[0]   <= '0;
      len[1]   <= '0;
      cur_clip <= 1'b0;
      reject_q <= 1'b0;
    end else begin
      reject_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (rec_req || (play_req && !sel_empty)) begin
            cur_clip <= clip_sel;
            addr     <= '0;
          end else if (play_req) begin
            reject_q <= 1'b1;
          end
        end
        REC, PLAY: begin
          if (fin) begin
            addr <= '0;
            if (state == REC) len[cur_clip] <= count;
          end else if (sample_tick) begin
            addr <= addr + ADDR_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  // Memory strobes and status outputs
  always_comb begin
    mem_en   = 2'b00;
    mem_we   = 2'b00;
    busy     = (state == REC) || (state == PLAY);
    done     = (state == DONE);
    reject   = reject_q;
    mem_addr = addr;
    if (busy) mem_en[cur_clip] = sample_tick;
    if (state == REC) mem_we[cur_clip] = sample_tick;
    clip_valid = {len[1] != '0, len[0] != '0};
  end

endmodule

// File: tb/tb_clip_sequencer.sv
// tb_clip_sequencer: directed plus random stimulus against a
// transaction-level model of the clip sequencer.
module tb_clip_sequencer;

  localparam int AW = 3;
  localparam int CL = 8;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          rec_req = 1'b0;
  logic          play_req = 1'b0;
  logic          stop = 1'b0;
  logic          clip_sel = 1'b0;
  logic          sample_tick = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [1:0]    mem_en;
  logic [1:0]    mem_we;
  logic          busy;
  logic          done;
  logic          reject;
  logic [1:0]    clip_valid;

  int n_checks = 0;
  int n_fail = 0;

  // Model: op 0 = none, 1 = recording, 2 = playing
  int m_op = 0;
  int m_clip = 0;
  int m_cnt = 0;
  int m_len [2] = '{0, 0};
  bit m_done = 0;
  bit m_rej = 0;
  bit m_known = 0;

  clip_sequencer #(.ADDR_W(AW), .CLIP_LEN(CL)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .rec_req(rec_req),
    .play_req(play_req),
    .stop(stop),
    .clip_sel(clip_sel),
    .sample_tick(sample_tick),
    .mem_addr(mem_addr),
    .mem_en(mem_en),
    .mem_we(mem_we),
    .busy(busy),
    .done(done),
    .reject(reject),
    .clip_valid(clip_valid)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic compare();
    int e_en;
    int e_we;
    int e_cv;
    e_en = 0;
    e_we = 0;
    if (m_op != 0 && sample_tick) e_en = 1 << m_clip;
    if (m_op == 1 && sample_tick) e_we = 1 << m_clip;
    e_cv = ((m_len[1] != 0) ? 2 : 0) + ((m_len[0] != 0) ? 1 : 0);
    check("busy", int'(busy), int'(m_op != 0));
    check("done", int'(done), int'(m_done));
    check("reject", int'(reject), int'(m_rej));
    check("mem_en", int'(mem_en), e_en);
    check("mem_we", int'(mem_we), e_we);
    check("clip_valid", int'(clip_valid), e_cv);
    if (m_op != 0) check("mem_addr", int'(mem_addr), m_cnt);
  endtask

  task automatic model_edge();
    bit nd;
    bit nr;
    int lim;
    int n;
    nd = 0;
    nr = 0;
    if (!reset_n) begin
      m_op = 0;
      m_clip = 0;
      m_cnt = 0;
      m_len[0] = 0;
      m_len[1] = 0;
      m_known = 1;
    end else if (m_op == 0 && !m_done) begin
      if (rec_req) begin
        m_op = 1;
        m_clip = int'(clip_sel);
        m_cnt = 0;
      end else if (play_req) begin
        if (m_len[clip_sel] != 0) begin
          m_op = 2;
          m_clip = int'(clip_sel);
          m_cnt = 0;
        end else begin
          nr = 1;
        end
      end
    end else if (m_op != 0) begin
      lim = (m_op == 1) ? CL : m_len[m_clip];
      n = m_cnt + int'(sample_tick);
      if (stop || n == lim) begin
        if (m_op == 1) m_len[m_clip] = n;
        m_op = 0;
        m_cnt = 0;
        nd = 1;
      end else begin
        m_cnt = n;
      end
    end
    m_done = nd;
    m_rej = nr;
  endtask

  task automatic step();
    @(negedge clock);
    if (m_known) compare();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic idle_inputs();
    rec_req = 0;
    play_req = 0;
    stop = 0;
    sample_tick = 0;
  endtask

  task automatic run_ticks(input int cycles, input int period);
    for (int i = 0; i < cycles; i++) begin
      sample_tick = (i % period == period - 1);
      step();
    end
    sample_tick = 0;
  endtask

  initial begin
    // Reset, then full record of clip 0
    idle_inputs();
    reset_n = 0;
    step();
    step();
    reset_n = 1;
    step();
    rec_req = 1;
    clip_sel = 0;
    step();
    rec_req = 0;
    run_ticks(40, 4);
    check("len0_full", int'(clip_valid), 1);

    // Play of empty clip 1 is rejected
    play_req = 1;
    clip_sel = 1;
    step();
    play_req = 0;
    run_ticks(4, 2);

    // Record clip 1, stop on the third tick, then play it back
    rec_req = 1;
    clip_sel = 1;
    step();
    rec_req = 0;
    run_ticks(5, 2);
    sample_tick = 1;
    stop = 1;
    step();
    stop = 0;
    sample_tick = 0;
    step();
    step();
    check("valid_after_stop", int'(clip_valid), 3);
    play_req = 1;
    clip_sel = 1;
    step();
    play_req = 0;
    run_ticks(12, 2);

    // Simultaneous requests on valid clip 0 choose record
    rec_req = 1;
    play_req = 1;
    clip_sel = 0;
    step();
    idle_inputs();
    run_ticks(40, 3);

    // Reset mid-record after five ticks
    rec_req = 1;
    clip_sel = 0;
    step();
    rec_req = 0;
    run_ticks(10, 2);
    reset_n = 0;
    step();
    reset_n = 1;
    step();
    check("valid_after_reset", int'(clip_valid), 0);

    // Zero-access record empties a full clip
    rec_req = 1;
    clip_sel = 0;
    step();
    rec_req = 0;
    run_ticks(20, 2);
    rec_req = 1;
    step();
    rec_req = 0;
    stop = 1;
    step();
    stop = 0;
    step();
    step();
    check("valid_zero_rec", int'(clip_valid), 0);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      rec_req = ($urandom % 16 == 0);
      play_req = ($urandom % 6 == 0);
      stop = ($urandom % 40 == 0);
      clip_sel = $urandom % 2;
      sample_tick = ($urandom % 3 == 0);
      reset_n = ($urandom % 500 != 0);
      step();
    end
    idle_inputs();
    reset_n = 1;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/clip_sequencer.md
# clip_sequencer

Sequences record and playback accesses to the two audio clip memories. It accepts record and play requests from the user-input logic and steps a shared address counter once per sample strobe. It drives each clip memory's enable and write-enable, and tracks how many samples each clip actually holds. It replaces fixed-duration timing with sample-accurate lengths, so playback stops exactly where recording stopped.

## Interface
Parameters:
- ADDR_W, 14, clip memory address width.
- CLIP_LEN, 16000, maximum samples per clip (2 s at 8 kHz). Must satisfy 1 ≤ CLIP_LEN ≤ 2^ADDR_W.

Ports:
- clock  in  1  system clock; all state changes on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- rec_req  in  1  level; request recording into clip_sel.
- play_req  in  1  level; request playback of clip_sel.
- stop  in  1  level; end the current record/play early.
- clip_sel  in  1  target clip (0 = clip 1, 1 = clip 2); sampled only on request acceptance.
- sample_tick  in  1  one-cycle strobe at the sample rate.
- mem_addr  out  ADDR_W  shared address to both clip memories.
- mem_en  out  2  per-clip memory enable, bit k = clip k.
- mem_we  out  2  per-clip write enable.
- busy  out  1  high in REC or PLAY.
- done  out  1  one-cycle pulse when an operation finishes.
- reject  out  1  one-cycle pulse when a play request targets an empty clip.
- clip_valid  out  2  bit k high when clip k holds ≥1 sample.

## Operation
States:
- IDLE
- REC
- PLAY
- DONE

Internal registers:
- cur_clip (1 bit).
- addr (ADDR_W bits).
- len0, len1: LEN_W = ADDR_W+1 bits each, range 0..CLIP_LEN.

IDLE:
- rec_req=1 → REC. cur_clip←clip_sel, addr←0.
- Otherwise play_req=1 with len[clip_sel]≠0 → PLAY. cur_clip←clip_sel, addr←0.
- Otherwise play_req=1 with len[clip_sel]=0 → stay IDLE and pulse reject for one cycle.
- rec_req has priority when both requests are high.
- stop is ignored in IDLE.

REC and PLAY outputs (combinational):
- mem_en[cur_clip] = sample_tick.
- In REC only: mem_we[cur_clip] = sample_tick.
- All other mem_en/mem_we bits are 0.
- mem_addr = addr.

Access counting and limits:
- Each cycle with sample_tick=1 in REC/PLAY is one access at addr. addr increments on that edge.
- limit = CLIP_LEN in REC, len[cur_clip] in PLAY.

Termination, evaluated at the edge:
- Condition: (sample_tick and addr = limit−1) or stop=1. Then → DONE.
- stop and sample_tick in the same cycle: the access still occurs and is counted.
- On leaving REC, len[cur_clip] ← number of accesses performed (addr plus 1 if this cycle had a tick).
- A REC stopped with 0 accesses sets len to 0, so that clip becomes invalid.
- PLAY never modifies len.

DONE:
- done=1 for one cycle, then → IDLE.
- Requests are not sampled in DONE.

Other output rules:
- clip_valid[k] = (len_k ≠ 0), registered through len.
- Requests held high re-trigger on the first IDLE cycle after DONE. Requesters must drop them.

## Timing
- Reset values (reset_n low at an edge): state IDLE, addr 0, len0=len1=0, cur_clip 0.
- All outputs are 0 after reset (busy, done, reject, mem_en, mem_we, mem_addr, clip_valid).
- Reset overrides any state, including mid-REC. A reset mid-REC discards the partial length; that clip's len becomes 0.
- Request latency: request high in IDLE at edge t → busy=1 from cycle t+1. The first access can occur in cycle t+1 if sample_tick=1.
- mem_en/mem_we are combinational from state and sample_tick. They are valid in the same cycle as the tick; the memory captures at the end of that cycle.
- Address wrap: addr never exceeds limit−1. There is no wrap-around.
- done pulses in the cycle after the terminating edge. The earliest next acceptance is 2 cycles after the terminating edge.
- reject pulses in the cycle after the rejected request edge.

## Test plan
Benches use CLIP_LEN=8 and ADDR_W=3.
- Reset then full record: rec_req, clip_sel=0, tick every 4 cycles → 8 accesses with mem_en=01, mem_we=01, addr 0..7; done once; clip_valid=01; len0=8.
- Play of empty clip: play_req, clip_sel=1 after reset → reject pulse, busy stays 0, no mem_en.
- Early stop on record: record clip 1, stop asserted in the same cycle as the 3rd tick → 3 accesses (addr 0,1,2), len1=3. Subsequent play of clip 1 → exactly 3 reads, mem_en=10, mem_we=00, addr 0..2, then done.
- Simultaneous requests: rec_req=play_req=1, clip_sel=0, clip 0 valid → REC chosen (mem_we asserted on ticks).
- Reset mid-record: reset_n low after 5 ticks into clip 0 → all outputs 0 next cycle, clip_valid=00.
- Stop with zero accesses: record clip 0 (len0=8), then record again with stop in the first REC cycle and no tick → len0=0, clip_valid[0]=0, done pulses.
